// File: rtl/alu_seq_n.sv
// Sequential W-bit ALU with ready/valid handshake on both sides.
// Results and flags are registered. A persistent carry chains ADC/SBB.
// Multiply is shift-add over W cycles; shifts move one bit per cycle.
module alu_seq_n #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(W)
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   AluOp,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [W-1:0] Result,
  output logic         Zero,
  output logic         Negative,
  output logic         Overflow,
  output logic         Carry
);

  // The cycle counter must hold W-1, which is the multiply length.
  localparam int unsigned CW = $clog2(W);

  localparam logic [3:0] OpAdd   = 4'h0;
  localparam logic [3:0] OpSub   = 4'h1;
  localparam logic [3:0] OpInc   = 4'h2;
  localparam logic [3:0] OpDec   = 4'h3;
  localparam logic [3:0] OpAdc   = 4'h4;
  localparam logic [3:0] OpSbb   = 4'h5;
  localparam logic [3:0] OpMul   = 4'h6;
  localparam logic [3:0] OpMulh  = 4'h7;
  localparam logic [3:0] OpAnd   = 4'h8;
  localparam logic [3:0] OpOr    = 4'h9;
  localparam logic [3:0] OpXor   = 4'hA;
  localparam logic [3:0] OpNot   = 4'hB;
  localparam logic [3:0] OpShl   = 4'hC;
  localparam logic [3:0] OpShr   = 4'hD;
  localparam logic [3:0] OpSar   = 4'hE;
  localparam logic [3:0] OpPassb = 4'hF;

  localparam logic [W-1:0] One = W'(1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e         state_q, state_d;

  // Latched operation
  logic [W-1:0]   a_q, b_q;
  logic [3:0]     op_q;
  logic           cin_q;

  // Iteration state: cycles remaining after the current one, plus a 2W work register
  // used as the multiply accumulator or the shift register.
  logic [CW-1:0]  cnt_q, cnt_init;
  logic [2*W-1:0] work_q, work_d, work_init;

  // Registered outputs
  logic [W-1:0]   result_q;
  logic           zero_q, neg_q, ovf_q, carry_q;

  logic           accept;
  logic           last;
  logic [SW-1:0]  in_amt, amt;

  // Datapath intermediates
  logic [W-1:0]   op2x;
  logic           cin;
  logic [W:0]     sum;
  logic [W:0]     madd;
  logic [2*W-1:0] mul_next;
  logic [W-1:0]   shl_next, shr_next, sar_next;
  logic [W-1:0]   res_val;
  logic           c_val, v_val;

  assign accept = (state_q == StIdle) && In_Valid;
  assign last   = (state_q == StExec) && (cnt_q == '0);
  assign in_amt = B[SW-1:0];
  assign amt    = b_q[SW-1:0];

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (In_Valid) state_d = StExec;
      StExec:  if (cnt_q == '0) state_d = StDone;
      StDone:  if (Out_Ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    In_Ready  = (state_q == StIdle);
    Out_Valid = (state_q == StDone);
  end

  // Cycle count and initial work value for the incoming operation
  always_comb begin
    cnt_init  = '0;
    work_init = {{W{1'b0}}, A};
    if (AluOp == OpMul || AluOp == OpMulh) begin
      cnt_init  = CW'(W - 1);
      work_init = {{W{1'b0}}, B};
    end else if ((AluOp == OpShl || AluOp == OpShr || AluOp == OpSar) && in_amt != '0) begin
      cnt_init = CW'(in_amt) - CW'(1);
    end
  end

  // Adder operand selection; subtract-type ops feed the inverted operand
  always_comb begin
    op2x = b_q;
    cin  = 1'b0;
    case (op_q)
      OpSub: begin
        op2x = ~b_q;
        cin  = 1'b1;
      end
      OpInc: op2x = One;
      OpDec: begin
        op2x = ~One;
        cin  = 1'b1;
      end
      OpAdc: cin = cin_q;
      OpSbb: begin
        op2x = ~b_q;
        cin  = cin_q;
      end
      default: ;
    endcase
    sum = {1'b0, a_q} + {1'b0, op2x} + {{W{1'b0}}, cin};
  end

  // One multiply step: add A into the high half when the multiplier LSB is set, then shift
  always_comb begin
    madd     = {1'b0, work_q[2*W-1:W]} + {1'b0, (work_q[0] ? a_q : {W{1'b0}})};
    mul_next = {madd, work_q[W-1:1]};
    shl_next = {work_q[W-2:0], 1'b0};
    shr_next = {1'b0, work_q[W-1:1]};
    sar_next = {work_q[W-1], work_q[W-1:1]};
  end

  // Work register advance for the current iteration
  always_comb begin
    work_d = work_q;
    if (accept) begin
      work_d = work_init;
    end else if (state_q == StExec) begin
      case (op_q)
        OpMul, OpMulh: work_d = mul_next;
        OpShl:         if (amt != '0) work_d = {{W{1'b0}}, shl_next};
        OpShr:         if (amt != '0) work_d = {{W{1'b0}}, shr_next};
        OpSar:         if (amt != '0) work_d = {{W{1'b0}}, sar_next};
        default: ;
      endcase
    end
  end

  // Result and flag values committed on the final execute cycle
  always_comb begin
    res_val = '0;
    c_val   = carry_q;
    v_val   = 1'b0;
    case (op_q)
      OpAdd, OpSub, OpInc, OpDec, OpAdc, OpSbb: begin
        res_val = sum[W-1:0];
        c_val   = sum[W];
        // Operand sign compare uses the adder input, so it covers add and subtract alike
        v_val   = (a_q[W-1] == op2x[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OpMul: begin
        res_val = mul_next[W-1:0];
        c_val   = |mul_next[2*W-1:W];
      end
      OpMulh: begin
        res_val = mul_next[2*W-1:W];
        c_val   = |mul_next[2*W-1:W];
      end
      OpAnd:   res_val = a_q & b_q;
      OpOr:    res_val = a_q | b_q;
      OpXor:   res_val = a_q ^ b_q;
      OpNot:   res_val = ~a_q;
      OpPassb: res_val = b_q;
      OpShl: begin
        res_val = a_q;
        if (amt != '0) begin
          res_val = shl_next;
          c_val   = work_q[W-1];
        end
      end
      OpShr: begin
        res_val = a_q;
        if (amt != '0) begin
          res_val = shr_next;
          c_val   = work_q[0];
        end
      end
      OpSar: begin
        res_val = a_q;
        if (amt != '0) begin
          res_val = sar_next;
          c_val   = work_q[0];
        end
      end
      default: ;
    endcase
  end

  // Operand latch; the carry seen by ADC/SBB is frozen at accept time
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cin_q <= 1'b0;
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      op_q  <= AluOp;
      cin_q <= carry_q;
    end
  end

  // Iteration counter and work register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      work_q <= '0;
    end else begin
      work_q <= work_d;
      if (accept) begin
        cnt_q <= cnt_init;
      end else if (state_q == StExec && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Result and flags update only on entry to DONE and hold until the next operation
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else if (last) begin
      result_q <= res_val;
      zero_q   <= (res_val == '0);
      neg_q    <= res_val[W-1];
      ovf_q    <= v_val;
      carry_q  <= c_val;
    end
  end

  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;
  assign Overflow = ovf_q;
  assign Carry    = carry_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Directed self-checking bench for alu_seq_n at W = 8 and W = 16.
module tb_alu_seq_n;

  localparam logic [3:0] OpAdd = 4'h0, OpSub = 4'h1, OpInc = 4'h2, OpDec = 4'h3;
  localparam logic [3:0] OpAdc = 4'h4, OpSbb = 4'h5, OpMul = 4'h6, OpMulh = 4'h7;
  localparam logic [3:0] OpAnd = 4'h8, OpOr = 4'h9, OpXor = 4'hA, OpNot = 4'hB;
  localparam logic [3:0] OpShl = 4'hC, OpShr = 4'hD, OpSar = 4'hE, OpPassb = 4'hF;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  f;    // {Z, N, V, C}
    logic [7:0]  lat;
  } vec_t;

  logic        clk, rst_n, out_ready;
  logic        in_valid8, in_ready8, out_valid8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  op8;
  logic        zero8, neg8, ovf8, carry8;
  logic        in_valid16, in_ready16, out_valid16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  op16;
  logic        zero16, neg16, ovf16, carry16;

  int checks = 0;
  int errors = 0;

  alu_seq_n #(.W(8)) dut8 (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid8), .In_Ready(in_ready8),
    .A(a8), .B(b8), .AluOp(op8), .Out_Valid(out_valid8), .Out_Ready(out_ready),
    .Result(res8), .Zero(zero8), .Negative(neg8), .Overflow(ovf8), .Carry(carry8)
  );

  alu_seq_n #(.W(16)) dut16 (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid16), .In_Ready(in_ready16),
    .A(a16), .B(b16), .AluOp(op16), .Out_Valid(out_valid16), .Out_Ready(out_ready),
    .Result(res16), .Zero(zero16), .Negative(neg16), .Overflow(ovf16), .Carry(carry16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, wait for Out_Valid, capture outputs, then let the handshake complete.
  // lat counts edges from the accept edge to the first cycle Out_Valid is seen.
  task automatic do_op(input bit wide, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, output logic [15:0] res, output logic [3:0] f,
                       output int lat);
    int n;
    n = 0;
    while (!(wide ? in_ready16 : in_ready8) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (wide) begin
      a16 = a; b16 = b; op16 = op; in_valid16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; op8 = op; in_valid8 = 1'b1;
    end
    @(posedge clk); #1;
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
    lat = 0;
    while (!(wide ? out_valid16 : out_valid8) && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!(wide ? out_valid16 : out_valid8)) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%h: Out_Valid never rose, want 1", op);
    end
    res = wide ? res16 : {8'h00, res8};
    f   = wide ? {zero16, neg16, ovf16, carry16} : {zero8, neg8, ovf8, carry8};
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({res8, zero8, neg8, ovf8, carry8, out_valid8} !== 14'h0) begin
      errors++;
      $display("FAIL reset8 outputs: got %h %b%b%b%b ov=%b want 00 0000 0", res8, zero8, neg8,
               ovf8, carry8, out_valid8);
    end
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++; $display("FAIL reset8 in_ready: got %b want 1", in_ready8);
    end
    checks++;
    if ({res16, zero16, neg16, ovf16, carry16, out_valid16, in_ready16} !== 23'h1) begin
      errors++;
      $display("FAIL reset16 outputs: got %h %b%b%b%b ov=%b ir=%b want 0000 0000 0 1", res16,
               zero16, neg16, ovf16, carry16, out_valid16, in_ready16);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    vec_t tv [10];
    logic [15:0] res;
    logic [3:0]  f;
    int          lat;
    tv[0] = '{OpAdd, 16'h007F, 16'h0001, 16'h0080, 4'b0110, 8'd1};
    tv[1] = '{OpSub, 16'h0000, 16'h0001, 16'h00FF, 4'b0100, 8'd1};
    tv[2] = '{OpSbb, 16'h0000, 16'h0000, 16'h00FF, 4'b0100, 8'd1};
    tv[3] = '{OpAdd, 16'h00FF, 16'h0001, 16'h0000, 4'b1001, 8'd1};
    tv[4] = '{OpAdc, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 8'd1};
    tv[5] = '{OpInc, 16'h007F, 16'h0000, 16'h0080, 4'b0110, 8'd1};
    tv[6] = '{OpDec, 16'h0080, 16'h0000, 16'h007F, 4'b0011, 8'd1};
    tv[7] = '{OpDec, 16'h0000, 16'h0000, 16'h00FF, 4'b0100, 8'd1};
    tv[8] = '{OpSbb, 16'h0005, 16'h0003, 16'h0001, 4'b0001, 8'd1};
    tv[9] = '{OpAdc, 16'h007F, 16'h0000, 16'h0080, 4'b0110, 8'd1};
    for (int i = 0; i < 10; i++) begin
      do_op(1'b0, tv[i].op, tv[i].a, tv[i].b, res, f, lat);
      checks++;
      if (res !== tv[i].res) begin
        errors++; $display("FAIL arith[%0d] result: got %h want %h", i, res, tv[i].res);
      end
      checks++;
      if (f !== tv[i].f) begin
        errors++; $display("FAIL arith[%0d] flags ZNVC: got %b want %b", i, f, tv[i].f);
      end
      checks++;
      if (lat !== int'(tv[i].lat)) begin
        errors++; $display("FAIL arith[%0d] latency: got %0d want %0d", i, lat, tv[i].lat);
      end
    end
  endtask

  task automatic test_mul;
    vec_t tv [5];
    logic [15:0] res;
    logic [3:0]  f;
    int          lat;
    tv[0] = '{OpMul,  16'h0010, 16'h0010, 16'h0000, 4'b1001, 8'd8};
    tv[1] = '{OpMulh, 16'h0010, 16'h0010, 16'h0001, 4'b0001, 8'd8};
    tv[2] = '{OpMul,  16'h00FF, 16'h00FF, 16'h0001, 4'b0001, 8'd8};
    tv[3] = '{OpMulh, 16'h00FF, 16'h00FF, 16'h00FE, 4'b0101, 8'd8};
    tv[4] = '{OpMul,  16'h0000, 16'h0005, 16'h0000, 4'b1000, 8'd8};
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, tv[i].op, tv[i].a, tv[i].b, res, f, lat);
      checks++;
      if (res !== tv[i].res) begin
        errors++; $display("FAIL mul[%0d] result: got %h want %h", i, res, tv[i].res);
      end
      checks++;
      if (f !== tv[i].f) begin
        errors++; $display("FAIL mul[%0d] flags ZNVC: got %b want %b", i, f, tv[i].f);
      end
      checks++;
      if (lat !== int'(tv[i].lat)) begin
        errors++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, tv[i].lat);
      end
    end
  endtask

  task automatic test_shift;
    vec_t tv [6];
    logic [15:0] res;
    logic [3:0]  f;
    int          lat;
    tv[0] = '{OpSar, 16'h0080, 16'h0003, 16'h00F0, 4'b0100, 8'd3};
    tv[1] = '{OpShl, 16'h0081, 16'h0001, 16'h0002, 4'b0001, 8'd1};
    tv[2] = '{OpShr, 16'h0055, 16'h0008, 16'h0055, 4'b0001, 8'd1};
    tv[3] = '{OpShr, 16'h0081, 16'h0004, 16'h0008, 4'b0000, 8'd4};
    tv[4] = '{OpShl, 16'h0001, 16'h0007, 16'h0080, 4'b0100, 8'd7};
    tv[5] = '{OpSar, 16'h007F, 16'h0001, 16'h003F, 4'b0001, 8'd1};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, tv[i].op, tv[i].a, tv[i].b, res, f, lat);
      checks++;
      if (res !== tv[i].res) begin
        errors++; $display("FAIL shift[%0d] result: got %h want %h", i, res, tv[i].res);
      end
      checks++;
      if (f !== tv[i].f) begin
        errors++; $display("FAIL shift[%0d] flags ZNVC: got %b want %b", i, f, tv[i].f);
      end
      checks++;
      if (lat !== int'(tv[i].lat)) begin
        errors++; $display("FAIL shift[%0d] latency: got %0d want %0d", i, lat, tv[i].lat);
      end
    end
  endtask

  // Carry enters at 1 and must survive every logic op
  task automatic test_logic;
    vec_t tv [6];
    logic [15:0] res;
    logic [3:0]  f;
    int          lat;
    tv[0] = '{OpAnd,   16'h00F0, 16'h003C, 16'h0030, 4'b0001, 8'd1};
    tv[1] = '{OpOr,    16'h00F0, 16'h000C, 16'h00FC, 4'b0101, 8'd1};
    tv[2] = '{OpXor,   16'h00FF, 16'h00FF, 16'h0000, 4'b1001, 8'd1};
    tv[3] = '{OpNot,   16'h000F, 16'h0000, 16'h00F0, 4'b0101, 8'd1};
    tv[4] = '{OpPassb, 16'h0012, 16'h00A5, 16'h00A5, 4'b0101, 8'd1};
    tv[5] = '{OpAdd,   16'h0000, 16'h0000, 16'h0000, 4'b1000, 8'd1};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, tv[i].op, tv[i].a, tv[i].b, res, f, lat);
      checks++;
      if (res !== tv[i].res) begin
        errors++; $display("FAIL logic[%0d] result: got %h want %h", i, res, tv[i].res);
      end
      checks++;
      if (f !== tv[i].f) begin
        errors++; $display("FAIL logic[%0d] flags ZNVC: got %b want %b", i, f, tv[i].f);
      end
      checks++;
      if (lat !== int'(tv[i].lat)) begin
        errors++; $display("FAIL logic[%0d] latency: got %0d want %0d", i, lat, tv[i].lat);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    a8 = 8'h01; b8 = 8'h02; op8 = OpAdd; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid8 !== 1'b1 || res8 !== 8'h03) begin
      errors++; $display("FAIL bp_first: got ov=%b res=%h want ov=1 res=03", out_valid8, res8);
    end
    // A competing request while DONE must be ignored
    a8 = 8'hFF; b8 = 8'hFF; op8 = OpMul; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid8, in_ready8, res8, zero8, neg8, ovf8, carry8} !== 14'b10_0000_0011_0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h ZNVC=%b%b%b%b want 1 0 03 0000", i,
                 out_valid8, in_ready8, res8, zero8, neg8, ovf8, carry8);
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid8, in_ready8);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready8 !== 1'b1 || res8 !== 8'h03) begin
      errors++;
      $display("FAIL bp_ignored: got ir=%b res=%h want ir=1 res=03", in_ready8, res8);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [15:0] res;
    logic [3:0]  f;
    int          lat;
    bit          seen;
    do_op(1'b0, OpAdd, 16'h00FF, 16'h0002, res, f, lat);
    checks++;
    if (res !== 16'h0001 || f !== 4'b0001) begin
      errors++; $display("FAIL rst_pre: got %h %b want 0001 0001", res, f);
    end
    a8 = 8'hFF; b8 = 8'hFF; op8 = OpMul; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({res8, zero8, neg8, ovf8, carry8, out_valid8, in_ready8} !== 15'h1) begin
      errors++;
      $display("FAIL rst_mid: got res=%h ZNVC=%b%b%b%b ov=%b ir=%b want 00 0000 0 1", res8,
               zero8, neg8, ovf8, carry8, out_valid8, in_ready8);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid8) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_no_out: got Out_Valid pulse=%b want 0", seen);
    end
  endtask

  task automatic test_w16;
    vec_t tv [6];
    logic [15:0] res;
    logic [3:0]  f;
    int          lat;
    tv[0] = '{OpAdd,  16'h7FFF, 16'h0001, 16'h8000, 4'b0110, 8'd1};
    tv[1] = '{OpMul,  16'h0100, 16'h0100, 16'h0000, 4'b1001, 8'd16};
    tv[2] = '{OpMulh, 16'h0100, 16'h0100, 16'h0001, 4'b0001, 8'd16};
    tv[3] = '{OpMul,  16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001, 8'd16};
    tv[4] = '{OpMulh, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b0101, 8'd16};
    tv[5] = '{OpSar,  16'h8000, 16'h0004, 16'hF800, 4'b0100, 8'd4};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b1, tv[i].op, tv[i].a, tv[i].b, res, f, lat);
      checks++;
      if (res !== tv[i].res) begin
        errors++; $display("FAIL w16[%0d] result: got %h want %h", i, res, tv[i].res);
      end
      checks++;
      if (f !== tv[i].f) begin
        errors++; $display("FAIL w16[%0d] flags ZNVC: got %b want %b", i, f, tv[i].f);
      end
      checks++;
      if (lat !== int'(tv[i].lat)) begin
        errors++; $display("FAIL w16[%0d] latency: got %0d want %0d", i, lat, tv[i].lat);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
    a8 = '0; b8 = '0; op8 = '0;
    a16 = '0; b16 = '0; op16 = '0;
    test_reset();
    test_arith();
    test_mul();
    test_shift();
    test_logic();
    test_backpressure();
    test_reset_mid_mul();
    test_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
